// File: rtl/d_inst_queue_if.sv
// Fetch-to-decode channel bundle for the decode-stage instruction queue.
// The queue takes the slave modport; the fetch/decode side takes the master.
interface d_inst_queue_if #(
  parameter int PRED_W = 8,
  parameter int EXC_W  = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic [1:0]             in_mask;
  logic [31:0]            in_pc;
  logic [1:0][31:0]       in_insts;
  logic [1:0][PRED_W-1:0] in_pred;
  logic [1:0][EXC_W-1:0]  in_exc;

  logic                   out_valid;
  logic                   out_ready;
  logic [1:0]             out_mask;
  logic [1:0][31:0]       out_pc;
  logic [1:0][31:0]       out_insts;
  logic [1:0][PRED_W-1:0] out_pred;
  logic [1:0][EXC_W-1:0]  out_exc;

  modport master (
    output in_valid, in_mask, in_pc, in_insts, in_pred, in_exc, out_ready,
    input  in_ready, out_valid, out_mask, out_pc, out_insts, out_pred, out_exc
  );

  modport slave (
    input  in_valid, in_mask, in_pc, in_insts, in_pred, in_exc, out_ready,
    output in_ready, out_valid, out_mask, out_pc, out_insts, out_pred, out_exc
  );
endinterface

// File: rtl/d_inst_queue.sv
// Decode-stage instruction queue: compacts 2-lane fetch packets into a circular buffer
// and presents up to 2 oldest instructions. Optional empty-queue bypass: D_INST_QUEUE_BYPASS_EN.
module d_inst_queue #(
  parameter int DEPTH  = 8,
  parameter int PRED_W = 8,
  parameter int EXC_W  = 8
) (
  input logic           clk,
  input logic           rst_n,
  input logic           flush,
  d_inst_queue_if.slave q
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0]       pc;
    logic [31:0]       inst;
    logic [PRED_W-1:0] pred;
    logic [EXC_W-1:0]  exc;
  } entry_t;

  function automatic logic [1:0] popcnt2(input logic [1:0] m);
    return {m[1] & m[0], m[1] ^ m[0]};
  endfunction

  entry_t         mem [DEPTH];
  logic [PW-1:0]  rd_ptr, wr_ptr;
  logic [CW-1:0]  count;

  entry_t         lane0, lane1, lane_c0;
  entry_t         slot0, slot1, o0, o1;
  logic           rdy, qv, byp, push_en, pop_en;
  logic [1:0]     qmask, pushed, popped;

  // Lane 1 always sits at pc|4; a lone lane 1 is compacted down into slot 0.
  always_comb begin
    lane0   = '{pc: q.in_pc,          inst: q.in_insts[0], pred: q.in_pred[0], exc: q.in_exc[0]};
    lane1   = '{pc: q.in_pc | 32'h4,  inst: q.in_insts[1], pred: q.in_pred[1], exc: q.in_exc[1]};
    lane_c0 = q.in_mask[0] ? lane0 : lane1;
  end

  assign slot0 = mem[rd_ptr];
  assign slot1 = mem[rd_ptr + PW'(1)];
  assign rdy   = (count <= CW'(DEPTH - 2));
  assign qv    = (count != '0);
  assign qmask = {count >= CW'(2), qv};

`ifdef D_INST_QUEUE_BYPASS_EN
  // Empty queue with a ready decoder: fetch lanes go straight through, nothing is stored.
  assign byp = (count == '0) & q.out_ready & ~flush;

  always_comb begin
    q.out_valid = qv;
    q.out_mask  = qmask;
    o0          = slot0;
    o1          = slot1;
    if (byp) begin
      q.out_valid = q.in_valid & (|q.in_mask);
      q.out_mask  = q.in_valid ? {&q.in_mask, |q.in_mask} : 2'b00;
      o0          = lane_c0;
      o1          = lane1;
    end
  end
`else
  assign byp = 1'b0;

  always_comb begin
    q.out_valid = qv;
    q.out_mask  = qmask;
    o0          = slot0;
    o1          = slot1;
  end
`endif

  assign q.in_ready     = rdy;
  assign q.out_pc[0]    = o0.pc;
  assign q.out_pc[1]    = o1.pc;
  assign q.out_insts[0] = o0.inst;
  assign q.out_insts[1] = o1.inst;
  assign q.out_pred[0]  = o0.pred;
  assign q.out_pred[1]  = o1.pred;
  assign q.out_exc[0]   = o0.exc;
  assign q.out_exc[1]   = o1.exc;

  assign push_en = q.in_valid & rdy & ~flush & ~byp;
  assign pop_en  = qv & q.out_ready & ~flush;
  assign pushed  = push_en ? popcnt2(q.in_mask) : 2'd0;
  assign popped  = pop_en  ? popcnt2(qmask)     : 2'd0;

  // Control state: flush beats any handshake in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(pushed);
      rd_ptr <= rd_ptr + PW'(popped);
      count  <= count + CW'(pushed) - CW'(popped);
    end
  end

  // Entry payload carries no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (push_en) begin
      if (|q.in_mask) mem[wr_ptr]          <= lane_c0;
      if (&q.in_mask) mem[wr_ptr + PW'(1)] <= lane1;
    end
  end
endmodule

// File: tb/tb_d_inst_queue.sv
// Directed + randomized scoreboard bench for d_inst_queue (queue model tracks expected entries).
module tb_d_inst_queue;
  localparam int DEPTH  = 8;
  localparam int PRED_W = 8;
  localparam int EXC_W  = 8;

  typedef logic [32+32+PRED_W+EXC_W-1:0] ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  d_inst_queue_if #(.PRED_W(PRED_W), .EXC_W(EXC_W)) qif ();

  d_inst_queue #(.DEPTH(DEPTH), .PRED_W(PRED_W), .EXC_W(EXC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .q     (qif)
  );

  ent_t sb[$];
  int   total = 0;
  int   bad   = 0;
  bit   acc;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t lane(input int k);
    logic [31:0] pc;
    pc = (k == 1) ? (qif.in_pc | 32'h4) : qif.in_pc;
    return {pc, qif.in_insts[k], qif.in_pred[k], qif.in_exc[k]};
  endfunction

  function automatic ent_t slot(input int k);
    return {qif.out_pc[k], qif.out_insts[k], qif.out_pred[k], qif.out_exc[k]};
  endfunction

  task automatic drive(input logic v, input logic [1:0] m, input logic [31:0] pc,
                       input logic [31:0] i0, input logic [31:0] i1);
    qif.in_valid    = v;
    qif.in_mask     = m;
    qif.in_pc       = pc;
    qif.in_insts[0] = i0;
    qif.in_insts[1] = i1;
    qif.in_pred[0]  = PRED_W'($urandom);
    qif.in_pred[1]  = PRED_W'($urandom);
    qif.in_exc[0]   = EXC_W'($urandom);
    qif.in_exc[1]   = EXC_W'($urandom);
  endtask

  // One cycle: check outputs against the model, then advance the model with the handshake.
  task automatic tick(output bit accepted);
    bit         rdy, byp, ev;
    logic [1:0] em;
    ent_t       c0, c1;
    #1;
    rdy = (sb.size() <= DEPTH - 2);
    chk("in_ready", qif.in_ready, rdy);
    byp = 1'b0;
`ifdef D_INST_QUEUE_BYPASS_EN
    byp = (sb.size() == 0) && qif.out_ready && !flush;
`endif
    c0 = qif.in_mask[0] ? lane(0) : lane(1);
    c1 = lane(1);
    if (byp) begin
      ev = qif.in_valid && (|qif.in_mask);
      em = ev ? {&qif.in_mask, 1'b1} : 2'b00;
    end else begin
      ev = (sb.size() >= 1);
      em = {sb.size() >= 2, sb.size() >= 1};
    end
    chk("out_valid", qif.out_valid, ev);
    chk("out_mask", qif.out_mask, em);
    if (em[0]) chk("slot0", slot(0), byp ? c0 : sb[0]);
    if (em[1]) chk("slot1", slot(1), byp ? c1 : sb[1]);
    accepted = qif.in_valid && rdy && !flush;
    if (flush) begin
      sb.delete();
    end else begin
      if (!byp && ev && qif.out_ready) repeat (em[1] ? 2 : 1) void'(sb.pop_front());
      if (accepted && !byp) begin
        if (|qif.in_mask) sb.push_back(c0);
        if (&qif.in_mask) sb.push_back(c1);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    bit a;
    qif.in_valid  = 1'b0;
    qif.out_ready = 1'b1;
    for (int n = 0; n < 40 && sb.size() != 0; n++) tick(a);
    chk("drain_timeout", sb.size(), 0);
    tick(a);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
    qif.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    tick(acc);
    chk("rst_valid", qif.out_valid, 1'b0);

    // Full packet, decoder stalled: both slots visible next cycle
    drive(1'b1, 2'b11, 32'h1c000000, 32'hAAAA0001, 32'hBBBB0002);
    tick(acc);
    drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
    #1;
    chk("t1_mask", qif.out_mask, 2'b11);
    chk("t1_pc0", qif.out_pc[0], 32'h1c000000);
    chk("t1_pc1", qif.out_pc[1], 32'h1c000004);
    chk("t1_rdy", qif.in_ready, 1'b1);
    #1;
    tick(acc);
    drain();

    // Lone lane 1 compacts into slot 0
    qif.out_ready = 1'b0;
    drive(1'b1, 2'b10, 32'h1c000008, 32'h0, 32'hCCCC0003);
    tick(acc);
    drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
    #1;
    chk("t2_mask", qif.out_mask, 2'b01);
    chk("t2_pc0", qif.out_pc[0], 32'h1c00000c);
    chk("t2_inst0", qif.out_insts[0], 32'hCCCC0003);
    #1;
    drain();

    // Fill to 7, hold a blocked packet, pop once, then it goes in
    qif.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'b11, 32'h2000_0000 + 32'(i * 8), 32'h1000 + 32'(i), 32'h2000 + 32'(i));
      tick(acc);
    end
    drive(1'b1, 2'b01, 32'h2000_0018, 32'h1003, 32'h0);
    tick(acc);
    drive(1'b1, 2'b11, 32'h2000_0020, 32'h1004, 32'h2004);
    #1;
    chk("full_rdy", qif.in_ready, 1'b0);
    #1;
    tick(acc);
    qif.out_ready = 1'b1;
    tick(acc);
    chk("full_pop_noacc", acc, 1'b0);
    qif.out_ready = 1'b0;
    tick(acc);
    chk("full_retry_acc", acc, 1'b1);
    drain();

    // Random masks and back-pressure across the buffer wrap
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 2'($urandom_range(0, 3)), 32'h3000_0000 + 32'(i * 8), $urandom, $urandom);
      acc = 1'b0;
      for (int t = 0; t < 12 && !acc; t++) begin
        qif.out_ready = (t > 4) ? 1'b1 : 1'($urandom_range(0, 1));
        tick(acc);
      end
      chk("rand_accept", acc, 1'b1);
    end
    drain();

    // Flush with 3 queued and a live handshake on both sides
    qif.out_ready = 1'b0;
    drive(1'b1, 2'b11, 32'h4000_0000, 32'hDEAD0000, 32'hDEAD0001);
    tick(acc);
    drive(1'b1, 2'b01, 32'h4000_0008, 32'hDEAD0002, 32'h0);
    tick(acc);
    flush = 1'b1;
    qif.out_ready = 1'b1;
    drive(1'b1, 2'b11, 32'h4000_0010, 32'hDEAD0003, 32'hDEAD0004);
    tick(acc);
    flush = 1'b0;
    drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
    #1;
    chk("flush_valid", qif.out_valid, 1'b0);
    chk("flush_rdy", qif.in_ready, 1'b1);
    #1;
    repeat (2) tick(acc);
    qif.out_ready = 1'b0;
    drive(1'b1, 2'b11, 32'h5000_0000, 32'h5555_0000, 32'h5555_0001);
    tick(acc);
    drain();

    // Empty queue, ready decoder: bypass shows it the same cycle, else one cycle later
    qif.out_ready = 1'b1;
    drive(1'b1, 2'b11, 32'h6000_0000, 32'h6666_0000, 32'h6666_0001);
    tick(acc);
    drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
    tick(acc);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
